// File: rtl/lsu_sram_master_pkg.sv
// Shared definitions for the LSU-to-SRAM master: access sizes, FSM states,
// alignment check and the sub-word lane select/merge helpers.
package lsu_sram_master_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MERGE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  // Size 2'b11 has no legal encoding, so it is reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = (off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      SZ_B:    r = 4'b0001 << off;
      SZ_H:    r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] rep;
    logic [31:0] res;
    logic [3:0]  sel;
    case (size)
      SZ_B:    rep = {4{wdata[7:0]}};
      SZ_H:    rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    sel = lane_sel(size, off);
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = rep[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_sram_master_load_align.sv
// Selects the addressed byte/half of a captured word and zero/sign extends it.
module lsu_load_align
  import lsu_sram_master_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [1:0]       i_off,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_B:    o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_sram_master.sv
// Single-outstanding load/store master for a 1R1W SRAM with async read.
// Sub-word stores read-modify-write through a MERGE cycle; every request ends in one RESP cycle.
module lsu_sram_master
  import lsu_sram_master_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    rd_addr0,
  output logic [AW-1:0]    wr_addr0,
  output logic [WIDTH-1:0] wr_din0,
  output logic             we0,
  input  logic [WIDTH-1:0] rd_dout0
);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [1:0]       r_size;
  logic             r_uns;
  logic             r_we;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_word;
  logic             r_err;

  logic             w_idle;
  logic             w_accept;
  logic             w_mis;
  logic             w_word_st;
  logic [WIDTH-1:0] w_load;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = req_valid & w_idle & rst;
  assign w_mis     = misaligned(req_size, req_addr[1:0]);
  assign w_word_st = w_accept & req_we & ~w_mis & (req_size == SZ_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_word  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_word  <= rd_dout0;
            r_err   <= w_mis;
            // Only aligned sub-word stores need the extra read-modify-write cycle.
            r_state <= (req_we && !w_mis && req_size != SZ_W) ? ST_MERGE : ST_RESP;
          end
        end
        ST_MERGE: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  lsu_load_align #(.WIDTH(WIDTH)) u_align (
    .i_word     (r_word),
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load)
  );

  assign req_ready = w_idle;
  assign rd_addr0  = w_idle ? req_addr : r_addr;
  assign we0       = w_word_st | (r_state == ST_MERGE);
  assign wr_addr0  = w_word_st ? req_addr : ((r_state == ST_MERGE) ? r_addr : '0);
  assign wr_din0   = w_word_st ? req_wdata :
                     ((r_state == ST_MERGE) ? merge_word(r_word, r_wdata, r_size, r_addr[1:0]) : '0);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = (r_state == ST_RESP) & r_err;
  assign rsp_rdata = ((r_state == ST_RESP) && !r_we && !r_err) ? w_load : '0;

endmodule

// File: tb/tb_lsu_sram_master.sv
// Bench for lsu_sram_master: SRAM model, transaction-level reference, per-cycle compare.
module tb_lsu_sram_master;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  rd_addr0;
  logic [3:0]  wr_addr0;
  logic [31:0] wr_din0;
  logic        we0;
  logic [31:0] rd_dout0;

  always #5 clk = ~clk;

  lsu_sram_master #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rd_addr0(rd_addr0), .wr_addr0(wr_addr0),
    .wr_din0(wr_din0), .we0(we0), .rd_dout0(rd_dout0)
  );

  // SRAM: asynchronous read, write on the rising edge.
  logic [31:0] mem [4] = '{default: 32'h0};
  assign rd_dout0 = mem[rd_addr0[AW-1:2]];
  always @(posedge clk) if (we0) mem[wr_addr0[AW-1:2]] <= wr_din0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model operates on whole transactions: word array plus due cycles.
  logic [31:0] ref_mem [4] = '{default: 32'h0};

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] sh, v;
    sh = w >> (8 * a);
    if (sz == 2'd0) begin
      v = sh & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = sh & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    int n;
    r = w;
    n = (sz == 2'd0) ? 1 : 2;
    for (int i = 0; i < n; i++) r[8*(a+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  int          cyc = 0;
  int          free_cyc = 0;
  int          rsp_cyc = 0;
  int          wr_cyc = 0;
  bit          rsp_pend = 0;
  bit          wr_pend = 0;
  logic [1:0]  wr_idx;
  logic [31:0] wr_val;
  logic [31:0] e_rd;
  logic        e_err;
  logic [31:0] last_exp_rd = '0;
  logic [31:0] last_exp_wd = '0;
  logic [31:0] last_dut_rd = '0;
  logic        last_dut_err = 1'b0;
  logic [31:0] last_dut_wd = '0;
  int          dut_rsp_cnt = 0;

  always @(negedge clk) begin
    bit          exp_ready, exp_rv, exp_we, mis;
    logic [1:0]  exp_wa, a, idx;
    logic [31:0] exp_wd, rd_now;
    logic        err_now;
    exp_we = 0; exp_wa = '0; exp_wd = '0;
    if (!rst) begin
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_we0", {31'b0, we0}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      rsp_pend = 0; wr_pend = 0; free_cyc = cyc;
    end else begin
      exp_ready = (cyc >= free_cyc);
      exp_rv = rsp_pend && (cyc == rsp_cyc);
      rd_now = e_rd; err_now = e_err;
      if (exp_rv) rsp_pend = 0;
      if (wr_pend && cyc == wr_cyc) begin
        exp_we = 1; exp_wa = wr_idx; exp_wd = wr_val;
        ref_mem[wr_idx] = wr_val; wr_pend = 0;
      end
      if (exp_ready && req_valid) begin
        a = req_addr[1:0]; idx = req_addr[3:2];
        mis = (req_size == 2'd3) || (req_size == 2'd1 && a[0]) || (req_size == 2'd2 && a != 2'd0);
        rsp_pend = 1; e_rd = '0; e_err = 0;
        if (mis) begin
          e_err = 1; rsp_cyc = cyc + 1; free_cyc = cyc + 2;
        end else if (!req_we) begin
          e_rd = model_load(ref_mem[idx], a, req_size, req_unsigned);
          rsp_cyc = cyc + 1; free_cyc = cyc + 2;
        end else if (req_size == 2'd2) begin
          exp_we = 1; exp_wa = idx; exp_wd = req_wdata; ref_mem[idx] = req_wdata;
          rsp_cyc = cyc + 1; free_cyc = cyc + 2;
        end else begin
          wr_pend = 1; wr_cyc = cyc + 1; wr_idx = idx;
          wr_val = model_merge(ref_mem[idx], req_wdata, req_size, a);
          rsp_cyc = cyc + 2; free_cyc = cyc + 3;
        end
      end
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      chk("we0", {31'b0, we0}, {31'b0, exp_we});
      if (exp_we) begin
        chk("wr_addr0_word", {30'b0, wr_addr0[3:2]}, {30'b0, exp_wa});
        chk("wr_din0", wr_din0, exp_wd);
        last_exp_wd = exp_wd;
      end
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rv});
      if (exp_rv) begin
        chk("rsp_rdata", rsp_rdata, rd_now);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, err_now});
        last_exp_rd = rd_now;
      end
      if (rsp_valid) begin
        last_dut_rd = rsp_rdata; last_dut_err = rsp_err; dut_rsp_cnt++;
      end
      if (we0) last_dut_wd = wr_din0;
    end
    cyc++;
  end

  int issued = 0;

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [3:0] a, input logic [31:0] wd);
    bit acc;
    acc = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    issued++;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout: got not-ready expected accept within 16 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    issue(1, 2'd2, 0, 4'h4, 32'hDEADBEEF);
    issue(0, 2'd2, 0, 4'h4, 32'h0);
    idle(2);
    chk("ld_word_dut", last_dut_rd, 32'hDEADBEEF);
    chk("ld_word_model", last_exp_rd, 32'hDEADBEEF);

    issue(1, 2'd2, 0, 4'h8, 32'h11223344);
    issue(1, 2'd0, 0, 4'h9, 32'h000000AA);
    idle(3);
    chk("merge_byte_dut", last_dut_wd, 32'h1122AA44);
    chk("merge_byte_model", last_exp_wd, 32'h1122AA44);

    issue(1, 2'd2, 0, 4'h0, 32'h000080FF);
    issue(0, 2'd1, 0, 4'h0, 32'h0);
    idle(2);
    chk("ld_half_signed", last_dut_rd, 32'hFFFF80FF);
    issue(0, 2'd0, 1, 4'h1, 32'h0);
    idle(2);
    chk("ld_byte_unsigned", last_dut_rd, 32'h00000080);
    chk("ld_byte_model", last_exp_rd, 32'h00000080);

    issue(1, 2'd2, 0, 4'h6, 32'hCAFEF00D);
    idle(2);
    chk("mis_err", {31'b0, last_dut_err}, 32'd1);
    chk("mis_rdata", last_dut_rd, 32'h0);
    chk("mis_mem", mem[1], 32'hDEADBEEF);

    issue(1, 2'd2, 0, 4'hC, 32'h12345678);
    issue(1, 2'd1, 0, 4'hE, 32'h00005555);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("abort_mem", mem[3], 32'h12345678);

    for (int n = 0; n < 400; n++) begin
      logic [1:0] sz;
      logic [3:0] a;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle(4);

    for (int i = 0; i < 4; i++) chk("final_mem", mem[i], ref_mem[i]);
    chk("rsp_count", dut_rsp_cnt, issued - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
